// File: rtl/mux_scanner_pkg.sv
// Shared constants and helpers for the scanning channel multiplexer.
package mux_scanner_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Round-robin increment that wraps correctly for any channel count.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mux_slice_sel.sv
// Combinational N:1 slice selector over a packed channel bus.
// Latency 0; no flow control, purely combinational.
module mux_slice_sel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          dat
);

  // Out-of-range selects fall through to zero rather than reading past the bus.
  always_comb begin
    dat = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) dat = data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_scanner.sv
// Registered N-channel mux with manual select or round-robin scan with dwell/hold.
// Latency 1 cycle; no backpressure, the consumer must take every cycle.
module mux_scanner
  import mux_scanner_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DWELL    = 10,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mode_i,
  input  logic [SEL_W-1:0]          select_i,
  input  logic                      hold_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]          data_o,
  output logic [SEL_W-1:0]          channel_o,
  output logic                      switch_o
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(CHANNELS);

  logic [SEL_W-1:0] ch, ch_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] sel_dat;

  always_comb begin
    ch_nxt  = ch;
    cnt_nxt = cnt;
    if (mode_i == MODE_MANUAL) begin
      cnt_nxt = '0;
      if ({1'b0, select_i} < CH_LIM) ch_nxt = select_i;
    end else if (!hold_i) begin
      if (cnt == CNT_MAX) begin
        cnt_nxt = '0;
        ch_nxt  = SEL_W'(wrap_inc(32'(ch), CHANNELS));
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Selecting on ch_nxt keeps data_o aligned with the channel registered alongside it.
  mux_slice_sel #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .SEL_W    (SEL_W)
  ) u_slice_sel (
    .data (data_i),
    .sel  (ch_nxt),
    .dat  (sel_dat)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch       <= '0;
      cnt      <= '0;
      data_o   <= '0;
      switch_o <= 1'b0;
    end else begin
      ch       <= ch_nxt;
      cnt      <= cnt_nxt;
      data_o   <= sel_dat;
      switch_o <= (ch_nxt != ch);
    end
  end

  assign channel_o = ch;

endmodule

// File: tb/tb_mux_scanner.sv
// Bench for mux_scanner: 4-channel and 3-channel instances against a dwell-count reference model.
module tb_mux_scanner;

  localparam int DW = 3;

  logic        clk = 1'b0;
  logic        rst, mode, hold;
  logic [1:0]  sel;
  logic [31:0] din;
  logic [7:0]  dat4, dat3;
  logic [1:0]  chn4, chn3;
  logic        sw4, sw3;

  always #5 clk = ~clk;

  mux_scanner #(.CHANNELS(4), .WIDTH(8), .DWELL(DW)) dut4 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .select_i(sel), .hold_i(hold),
    .data_i(din), .data_o(dat4), .channel_o(chn4), .switch_o(sw4)
  );

  mux_scanner #(.CHANNELS(3), .WIDTH(8), .DWELL(DW)) dut3 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .select_i(sel), .hold_i(hold),
    .data_i(din[23:0]), .data_o(dat3), .channel_o(chn3), .switch_o(sw3)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Model: in scan, channel = (entry channel + non-held scan cycles / DWELL) mod CHANNELS.
  int m4_base = 0, m4_steps = 0, m4_ch = 0;
  int m3_base = 0, m3_steps = 0, m3_ch = 0;
  logic [7:0] m4_dat = 8'h00, m3_dat = 8'h00;
  logic m4_sw = 1'b0, m3_sw = 1'b0;

  task automatic upd(input int c, inout int base, inout int steps, inout int ch,
                     output logic [7:0] dat, output logic sw);
    int n;
    if (rst) begin
      n = 0; base = 0; steps = 0;
    end else if (!mode) begin
      n = (int'(sel) < c) ? int'(sel) : ch;
      base = n; steps = 0;
    end else if (hold) begin
      n = ch;
    end else begin
      steps++;
      n = (base + steps / DW) % c;
    end
    dat = rst ? 8'h00 : din[n*8 +: 8];
    sw  = !rst && (n != ch);
    ch  = n;
  endtask

  task automatic tick();
    @(posedge clk);
    upd(4, m4_base, m4_steps, m4_ch, m4_dat, m4_sw);
    upd(3, m3_base, m3_steps, m3_ch, m3_dat, m3_sw);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'($urandom); sel = 2'($urandom); hold = 1'($urandom); din = $urandom;
    tick();
    tick();
    cmp_cnt++;
    if ({dat4, chn4, sw4} !== 11'd0) begin
      err_cnt++;
      $display("FAIL reset4 got dat=%h ch=%0d sw=%b want 00/0/0", dat4, chn4, sw4);
    end
    cmp_cnt++;
    if ({dat3, chn3, sw3} !== 11'd0) begin
      err_cnt++;
      $display("FAIL reset3 got dat=%h ch=%0d sw=%b want 00/0/0", dat3, chn3, sw3);
    end
    rst = 1'b0; mode = 1'b0; sel = 2'd0; hold = 1'b0; din = 32'hA3A2A1A0;
  endtask

  task automatic test_manual();
    logic [1:0] s[4]  = '{2'd0, 2'd2, 2'd2, 2'd3};
    logic [7:0] ed[4] = '{8'hA0, 8'hA2, 8'hA2, 8'hA3};
    logic       es[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      sel = s[i];
      tick();
      cmp_cnt++;
      if (dat4 !== ed[i] || chn4 !== s[i] || sw4 !== es[i]) begin
        err_cnt++;
        $display("FAIL manual[%0d] got dat=%h ch=%0d sw=%b want %h/%0d/%b",
                 i, dat4, chn4, sw4, ed[i], s[i], es[i]);
      end
    end
  endtask

  task automatic test_scan();
    logic [1:0] ec[13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                          2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    logic       esw;
    mode = 1'b0; sel = 2'd0;
    tick();
    for (int i = 0; i < 13; i++) begin
      if (i > 0) begin
        mode = 1'b1;
        tick();
      end
      esw = (i == 0) ? 1'b1 : (ec[i] != ec[i-1]);
      cmp_cnt++;
      if (chn4 !== ec[i] || sw4 !== esw || dat4 !== (8'hA0 + 8'(ec[i]))) begin
        err_cnt++;
        $display("FAIL scan[%0d] got ch=%0d sw=%b dat=%h want ch=%0d sw=%b", i, chn4, sw4, dat4, ec[i], esw);
      end
    end
  endtask

  task automatic test_hold();
    int ones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (chn4 == 2'd1) ones++;
    end
    hold = 1'b1;
    for (int h = 0; h < 5; h++) begin
      if (h == 2) din[15:8] = 8'h5C;
      tick();
      if (chn4 == 2'd1) ones++;
      if (h == 2) begin
        cmp_cnt++;
        if (dat4 !== 8'h5C) begin
          err_cnt++;
          $display("FAIL hold_live_data got %h want 5c", dat4);
        end
      end
    end
    hold = 1'b0; din[15:8] = 8'hA1;
    for (int i = 0; i < 10 && chn4 == 2'd1; i++) begin
      tick();
      if (chn4 == 2'd1) ones++;
    end
    cmp_cnt++;
    if (ones != 8 || chn4 !== 2'd2) begin
      err_cnt++;
      $display("FAIL hold_dwell got %0d cycles on ch1 then ch=%0d want 8 then 2", ones, chn4);
    end
  endtask

  task automatic test_mode_change();
    tick();
    cmp_cnt++;
    if (chn4 !== 2'd2) begin
      err_cnt++;
      $display("FAIL mode_pre got ch=%0d want 2", chn4);
    end
    mode = 1'b0; sel = 2'd0;
    tick();
    cmp_cnt++;
    if (chn4 !== 2'd0 || sw4 !== 1'b1 || dat4 !== 8'hA0) begin
      err_cnt++;
      $display("FAIL scan_to_manual got ch=%0d sw=%b dat=%h want 0/1/a0", chn4, sw4, dat4);
    end
    mode = 1'b1;
    tick();
    tick();
    cmp_cnt++;
    if (chn4 !== 2'd0 || sw4 !== 1'b0) begin
      err_cnt++;
      $display("FAIL manual_to_scan_dwell got ch=%0d sw=%b want 0/0", chn4, sw4);
    end
    tick();
    cmp_cnt++;
    if (chn4 !== 2'd1 || sw4 !== 1'b1) begin
      err_cnt++;
      $display("FAIL manual_to_scan_adv got ch=%0d sw=%b want 1/1", chn4, sw4);
    end
  endtask

  task automatic test_out_of_range();
    mode = 1'b0; sel = 2'd2;
    tick();
    sel = 2'd3;
    tick();
    cmp_cnt++;
    if (chn3 !== 2'd2 || sw3 !== 1'b0 || dat3 !== 8'hA2) begin
      err_cnt++;
      $display("FAIL out_of_range got ch=%0d sw=%b dat=%h want 2/0/a2", chn3, sw3, dat3);
    end
    cmp_cnt++;
    if (chn4 !== 2'd3 || sw4 !== 1'b1) begin
      err_cnt++;
      $display("FAIL in_range_ch3 got ch=%0d sw=%b want 3/1", chn4, sw4);
    end
  endtask

  task automatic test_mid_reset();
    mode = 1'b1; hold = 1'b0;
    tick();
    rst = 1'b1; hold = 1'b1;
    tick();
    cmp_cnt++;
    if ({dat4, chn4, sw4, dat3, chn3, sw3} !== 22'd0) begin
      err_cnt++;
      $display("FAIL mid_reset got %h/%0d/%b %h/%0d/%b want zeros", dat4, chn4, sw4, dat3, chn3, sw3);
    end
    rst = 1'b0; hold = 1'b0; mode = 1'b0; sel = 2'd0;
    tick();
    cmp_cnt++;
    if (chn4 !== 2'd0 || sw4 !== 1'b0 || dat4 !== 8'hA0) begin
      err_cnt++;
      $display("FAIL post_reset got ch=%0d sw=%b dat=%h want 0/0/a0", chn4, sw4, dat4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel  = 2'($urandom);
      hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) din = $urandom;
      tick();
      cmp_cnt++;
      if (dat4 !== m4_dat || chn4 !== 2'(m4_ch) || sw4 !== m4_sw) begin
        err_cnt++;
        $display("FAIL random4[%0d] got %h/%0d/%b want %h/%0d/%b", i, dat4, chn4, sw4, m4_dat, m4_ch, m4_sw);
      end
      cmp_cnt++;
      if (dat3 !== m3_dat || chn3 !== 2'(m3_ch) || sw3 !== m3_sw) begin
        err_cnt++;
        $display("FAIL random3[%0d] got %h/%0d/%b want %h/%0d/%b", i, dat3, chn3, sw3, m3_dat, m3_ch, m3_sw);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; hold = 1'b0; din = 32'hA3A2A1A0;
    test_reset();
    test_manual();
    test_scan();
    test_hold();
    test_mode_change();
    test_out_of_range();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
